// File: rtl/maze_pkg.sv
// Shared maze geometry, wall-bit positions, direction and FSM encodings for the
// player movement controller.
package maze_pkg;

  localparam int unsigned ROWS       = 15;
  localparam int unsigned COLS       = 15;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned START_ROW  = 14;
  localparam int unsigned START_COL  = 0;
  localparam int unsigned FIN_ROW    = 0;
  localparam int unsigned FIN_COL    = 14;
  localparam int unsigned DEF_CNT_W  = 10;

  localparam int unsigned WALL_TOP    = 3;
  localparam int unsigned WALL_RIGHT  = 2;
  localparam int unsigned WALL_BOTTOM = 1;
  localparam int unsigned WALL_LEFT   = 0;

  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_R = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CHECK = 2'd2,
    ST_WON   = 2'd3
  } state_e;

  // Wall-nibble bit guarding the side of the cell the player would cross.
  function automatic logic [1:0] wall_idx(input dir_e dir);
    logic [1:0] idx;
    case (dir)
      DIR_U:   idx = 2'(WALL_TOP);
      DIR_D:   idx = 2'(WALL_BOTTOM);
      DIR_L:   idx = 2'(WALL_LEFT);
      default: idx = 2'(WALL_RIGHT);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/maze_move_controller_step.sv
// Evaluates one candidate move: blocked by a wall or the grid edge, otherwise
// the neighbouring cell in the requested direction.
module maze_move_controller_step
  import maze_pkg::*;
(
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] col,
  input  dir_e             dir,
  input  logic [3:0]       walls,
  output logic             blocked_c,
  output logic [POS_W-1:0] next_row_c,
  output logic [POS_W-1:0] next_col_c
);

  logic at_edge;

  always_comb begin
    at_edge    = 1'b0;
    next_row_c = row;
    next_col_c = col;
    case (dir)
      DIR_U:   at_edge = (row == POS_W'(0));
      DIR_D:   at_edge = (row == POS_W'(ROWS - 1));
      DIR_L:   at_edge = (col == POS_W'(0));
      default: at_edge = (col == POS_W'(COLS - 1));
    endcase
    // The grid edge blocks regardless of what the ROM reports.
    blocked_c = at_edge | walls[wall_idx(dir)];
    if (!blocked_c) begin
      case (dir)
        DIR_U:   next_row_c = row - POS_W'(1);
        DIR_D:   next_row_c = row + POS_W'(1);
        DIR_L:   next_col_c = col - POS_W'(1);
        default: next_col_c = col + POS_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/maze_move_controller.sv
// Player movement sequencer: latches a direction pulse, fetches the current
// cell's walls from maze_rom, then accepts or blocks the move.
module maze_move_controller
  import maze_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             restart,
  output logic [3:0]       rom_row,
  output logic [3:0]       rom_col,
  input  logic [3:0]       rom_walls,
  output logic [3:0]       player_row,
  output logic [3:0]       player_col,
  output logic [CNT_W-1:0] move_count,
  output logic             busy,
  output logic             bump,
  output logic             won
);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             bump_q, bump_d;
  logic             won_q, won_d;

  logic             blocked_c;
  logic [POS_W-1:0] next_row_c;
  logic [POS_W-1:0] next_col_c;

  maze_move_controller_step u_step (
    .row        (row_q),
    .col        (col_q),
    .dir        (dir_q),
    .walls      (rom_walls),
    .blocked_c  (blocked_c),
    .next_row_c (next_row_c),
    .next_col_c (next_col_c)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    bump_d  = 1'b0;
    if (restart) begin
      state_d = ST_IDLE;
      row_d   = POS_W'(START_ROW);
      col_d   = POS_W'(START_COL);
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (btn_u | btn_d | btn_l | btn_r) begin
            state_d = ST_FETCH;
            if (btn_u)      dir_d = DIR_U;
            else if (btn_d) dir_d = DIR_D;
            else if (btn_l) dir_d = DIR_L;
            else            dir_d = DIR_R;
          end
        end
        ST_FETCH: state_d = ST_CHECK;
        ST_CHECK: begin
          if (blocked_c) begin
            bump_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d   = next_row_c;
            col_d   = next_col_c;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = (next_row_c == POS_W'(FIN_ROW) && next_col_c == POS_W'(FIN_COL))
                      ? ST_WON : ST_IDLE;
          end
        end
        ST_WON: state_d = ST_WON;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    won_d  = (state_d == ST_WON);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_U;
      row_q   <= POS_W'(START_ROW);
      col_q   <= POS_W'(START_COL);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      bump_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      bump_q  <= bump_d;
      won_q   <= won_d;
    end
  end

  // The ROM address follows the player so it is already stable during FETCH.
  assign rom_row    = row_q;
  assign rom_col    = col_q;
  assign player_row = row_q;
  assign player_col = col_q;
  assign move_count = cnt_q;
  assign busy       = busy_q;
  assign bump       = bump_q;
  assign won        = won_q;

endmodule

// File: tb/tb_maze_move_controller.sv
// Randomized self-checking bench for maze_move_controller against a cell-level
// reference model of the maze and the player.
module tb_maze_move_controller;
  import maze_pkg::*;

  localparam int CW      = 10;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic          restart = 1'b0;
  logic [3:0]    rom_row, rom_col;
  logic [3:0]    rom_walls = 4'h0;
  logic [3:0]    player_row, player_col;
  logic [CW-1:0] move_count;
  logic          busy, bump, won;

  logic [3:0] maze [15][15];

  int vectors = 0;
  int miscompares = 0;

  int m_row, m_col, m_cnt;
  bit m_won;

  maze_move_controller #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .restart    (restart),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_walls  (rom_walls),
    .player_row (player_row),
    .player_col (player_col),
    .move_count (move_count),
    .busy       (busy),
    .bump       (bump),
    .won        (won)
  );

  always #5 clk = ~clk;

  // Behavioural maze_rom: one-cycle synchronous read.
  always @(posedge clk) begin
    if (rom_row < 4'd15 && rom_col < 4'd15) rom_walls <= maze[rom_row][rom_col];
    else                                    rom_walls <= 4'hF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {btn_u, btn_d, btn_l, btn_r} = b;
  endtask

  task automatic fill_maze(input logic [3:0] v);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        maze[r][c] = v;
  endtask

  function automatic bit model_blocked(input int r, input int c, input int d);
    logic [3:0] w;
    w = maze[r][c];
    case (d)
      0:       return (r == 0)        || w[3];
      1:       return (r == ROWS - 1) || w[1];
      2:       return (c == 0)        || w[0];
      default: return (c == COLS - 1) || w[2];
    endcase
  endfunction

  task automatic model_start();
    m_row = START_ROW;
    m_col = START_COL;
    m_cnt = 0;
    m_won = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".row"},  32'(player_row), 32'(m_row));
    check({tag, ".col"},  32'(player_col), 32'(m_col));
    check({tag, ".cnt"},  32'(move_count), 32'(m_cnt));
    check({tag, ".won"},  32'(won),        32'(m_won));
    check({tag, ".busy"}, 32'(busy),       32'(m_won));
  endtask

  // btns = {u,d,l,r}; a drop pulse is injected while the controller is busy.
  task automatic do_move(input string tag, input logic [3:0] btns,
                         input bit drop, input logic [3:0] drop_btns);
    int  d;
    bit  blk;
    set_btns(btns);
    tick();
    set_btns(4'h0);
    if (btns == 4'h0) begin
      check_state({tag, ".idle"});
      return;
    end
    if (m_won) begin
      if (drop) set_btns(drop_btns);
      tick();
      set_btns(4'h0);
      tick();
      check_state({tag, ".won_ign"});
      return;
    end
    d = btns[3] ? 0 : btns[2] ? 1 : btns[1] ? 2 : 3;
    blk = model_blocked(m_row, m_col, d);
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    check({tag, ".bump1"}, 32'(bump), 32'd0);
    if (drop) set_btns(drop_btns);
    tick();
    set_btns(4'h0);
    check({tag, ".busy2"}, 32'(busy), 32'd1);
    check({tag, ".bump2"}, 32'(bump), 32'd0);
    tick();
    if (!blk) begin
      case (d)
        0:       m_row--;
        1:       m_row++;
        2:       m_col--;
        default: m_col++;
      endcase
      m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (m_row == FIN_ROW && m_col == FIN_COL) m_won = 1'b1;
    end
    check({tag, ".bump"}, 32'(bump), 32'(blk));
    check_state(tag);
  endtask

  task automatic do_restart(input string tag, input logic [3:0] btns);
    restart = 1'b1;
    set_btns(btns);
    tick();
    restart = 1'b0;
    set_btns(4'h0);
    model_start();
    check_state(tag);
    check({tag, ".bump"}, 32'(bump), 32'd0);
  endtask

  initial begin
    fill_maze(4'h0);
    maze[START_ROW][START_COL] = 4'h3;
    model_start();

    // Reset held for three cycles
    reset_n = 1'b0;
    repeat (3) tick();
    check_state("reset");
    check("reset.bump", 32'(bump), 32'd0);
    check("reset.rom_row", 32'(rom_row), 32'(START_ROW));
    check("reset.rom_col", 32'(rom_col), 32'(START_COL));
    reset_n = 1'b1;
    tick();

    // Walled moves at the start cell, then open move, then priority with a drop
    do_move("wall_l", 4'b0010, 1'b0, 4'h0);
    do_move("wall_d", 4'b0100, 1'b0, 4'h0);
    do_move("open_u", 4'b1000, 1'b0, 4'h0);
    do_move("prio_ur", 4'b1001, 1'b1, 4'b0001);
    do_move("prio_dl", 4'b0110, 1'b1, 4'b1111);
    do_move("prio_lr", 4'b0011, 1'b0, 4'h0);

    // Open maze: climb to the top, then run right into the finish cell
    do_restart("rst_a", 4'b1000);
    fill_maze(4'h0);
    for (int i = 0; i < 14; i++) do_move("win_u", 4'b1000, 1'b0, 4'h0);
    do_move("edge_u", 4'b1000, 1'b0, 4'h0);
    for (int i = 0; i < 14; i++) do_move("win_r", 4'b0001, 1'b0, 4'h0);
    check("win.won", 32'(won), 32'd1);
    do_move("won_ign_d", 4'b0100, 1'b0, 4'h0);
    do_move("won_ign_l", 4'b0010, 1'b1, 4'b0010);
    do_restart("rst_won", 4'b0100);

    // Reset in the CHECK cycle of an open move discards it
    do_move("pre_rst", 4'b1000, 1'b0, 4'h0);
    set_btns(4'b1000);
    tick();
    set_btns(4'h0);
    tick();
    reset_n = 1'b0;
    #2;
    model_start();
    check_state("midrst");
    check("midrst.bump", 32'(bump), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_state("midrst.after");
    check("midrst.after.bump", 32'(bump), 32'd0);

    // Counter saturation by bouncing between rows 14 and 13
    for (int i = 0; i < CNT_MAX + 3; i++)
      do_move("sat", (i % 2 == 0) ? 4'b1000 : 4'b0100, 1'b0, 4'h0);
    check("sat.cnt", 32'(move_count), 32'(CNT_MAX));

    // Random maze, random request mixes, drops and restarts
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        maze[r][c] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
    do_restart("rst_rand", 4'h0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0 || (m_won && $urandom_range(0, 3) == 0))
        do_restart("rand_rst", 4'($urandom_range(0, 15)));
      else
        do_move("rand", 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
                4'($urandom_range(1, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
